// File: rtl/vc_dest_demux.sv
// Two-stage demux between the VC0/VC1 FIFOs and the D0/D1 destination FIFOs.
// VC0 has strict priority. Define DEMUX_STATS_EN to add the d0/d1/drop event counters.
module vc_dest_demux #(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [BW-1:0] VC0_data,
    input  logic          VC0_empty,
    output logic          VC0_rd,
    input  logic [BW-1:0] VC1_data,
    input  logic          VC1_empty,
    output logic          VC1_rd,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    input  logic          D0_full,
    input  logic          D1_full,
    output logic          D0_wr,
    output logic [BW-1:0] D0_data_in,
    output logic          D1_wr,
    output logic [BW-1:0] D1_data_in,
    output logic          drop_error,
    output logic          busy
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]    d0_count,
    output logic [7:0]    d1_count,
    output logic [7:0]    drop_count
`endif
);

    logic          can_pop;
    logic          s1_valid;
    logic          s1_src;
    logic [BW-1:0] s1_data;
    logic          s1_dest;
    logic          dest_full;
    logic          s1_accept;
    logic          s1_drop;
    logic          s2_valid;
    logic          s2_dest;
    logic [BW-1:0] s2_data;

    // Strobes are gated by reset so nothing is popped while reset is held.
    assign can_pop = !D0_almost_full && !D1_almost_full;
    assign VC0_rd  = reset_L && can_pop && !VC0_empty;
    assign VC1_rd  = reset_L && can_pop && VC0_empty && !VC1_empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s1_valid <= 1'b0;
            s1_src   <= 1'b0;
        end else begin
            s1_valid <= VC0_rd || VC1_rd;
            s1_src   <= VC1_rd;
        end
    end

    always_comb begin
        s1_data   = s1_src ? VC1_data : VC0_data;
        s1_dest   = s1_data[DEST_BIT];
        dest_full = s1_dest ? D1_full : D0_full;
        s1_accept = s1_valid && !dest_full;
        s1_drop   = s1_valid && dest_full;
    end

    // A word whose destination is full in stage 1 never reaches stage 2.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s2_valid   <= 1'b0;
            s2_dest    <= 1'b0;
            s2_data    <= '0;
            drop_error <= 1'b0;
        end else begin
            s2_valid <= s1_accept;
            if (s1_accept) begin
                s2_data <= s1_data;
                s2_dest <= s1_dest;
            end
            if (s1_drop) begin
                drop_error <= 1'b1;
            end
        end
    end

    assign D0_wr      = s2_valid && !s2_dest;
    assign D1_wr      = s2_valid && s2_dest;
    assign D0_data_in = s2_data;
    assign D1_data_in = s2_data;
    assign busy       = s1_valid || s2_valid;

`ifdef DEMUX_STATS_EN
    // Counters update on the same edge that launches the write or records the drop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0_count   <= 8'd0;
            d1_count   <= 8'd0;
            drop_count <= 8'd0;
        end else begin
            if (s1_accept && !s1_dest) begin
                d0_count <= d0_count + 8'd1;
            end
            if (s1_accept && s1_dest) begin
                d1_count <= d1_count + 8'd1;
            end
            if (s1_drop) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_dest_demux.sv
// Directed self-checking bench for vc_dest_demux with simple VC FIFO models.
// Stats outputs are checked only when DEMUX_STATS_EN is defined.
module tb_vc_dest_demux;

    localparam int BW   = 6;
    localparam int DEST = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [BW-1:0] VC0_data = 6'h2A;
    logic [BW-1:0] VC1_data = 6'h15;
    logic          VC0_empty, VC1_empty, VC0_rd, VC1_rd;
    logic          D0_almost_full, D1_almost_full, D0_full, D1_full;
    logic          D0_wr, D1_wr, drop_error, busy;
    logic [BW-1:0] D0_data_in, D1_data_in;
`ifdef DEMUX_STATS_EN
    logic [7:0]    d0_count, d1_count, drop_count;
`endif

    logic [BW-1:0] mem0 [0:31];
    logic [BW-1:0] mem1 [0:31];
    int            wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic          forceAvail = 1'b0;
    logic [BW-1:0] expWords[$];
    int            total = 0;
    int            bad = 0;

    vc_dest_demux #(.BW(BW), .DEST_BIT(DEST)) dut (
        .clk(clk), .reset_L(reset_L),
        .VC0_data(VC0_data), .VC0_empty(VC0_empty), .VC0_rd(VC0_rd),
        .VC1_data(VC1_data), .VC1_empty(VC1_empty), .VC1_rd(VC1_rd),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .D0_full(D0_full), .D1_full(D1_full),
        .D0_wr(D0_wr), .D0_data_in(D0_data_in),
        .D1_wr(D1_wr), .D1_data_in(D1_data_in),
        .drop_error(drop_error), .busy(busy)
`ifdef DEMUX_STATS_EN
        , .d0_count(d0_count), .d1_count(d1_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    // VC FIFO models: read data appears the cycle after the pop strobe.
    assign VC0_empty = !(forceAvail || (wr0 != rd0));
    assign VC1_empty = !(forceAvail || (wr1 != rd1));

    always @(posedge clk) begin
        if (VC0_rd && (wr0 != rd0)) begin
            VC0_data <= mem0[rd0];
            rd0      <= rd0 + 1;
        end
        if (VC1_rd && (wr1 != rd1)) begin
            VC1_data <= mem1[rd1];
            rd1      <= rd1 + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [BW-1:0] w);
        if (ch == 0) begin
            mem0[wr0] = w;
            wr0++;
        end else begin
            mem1[wr1] = w;
            wr1++;
        end
    endtask

    // Cycle 1 is the current cycle; writes must follow pops by exactly two cycles.
    task automatic runWindow(input string name, input int n, input logic [15:0] pop0,
                             input logic [15:0] pop1, input logic [15:0] af);
        int            idx;
        logic [15:0]   pops;
        logic          expBusy;
        logic          expWrite;
        logic [BW-1:0] w;
        idx  = 0;
        pops = pop0 | pop1;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) @(negedge clk);
            D0_almost_full = af[c-1];
            #1;
            checkOutput($sformatf("%s_rd0_c%0d", name, c), VC0_rd, pop0[c-1]);
            checkOutput($sformatf("%s_rd1_c%0d", name, c), VC1_rd, pop1[c-1]);
            expBusy  = 1'b0;
            expWrite = 1'b0;
            if (c >= 2) expBusy = pops[c-2];
            if (c >= 3) begin
                expWrite = pops[c-3];
                expBusy  = expBusy || pops[c-3];
            end
            checkOutput($sformatf("%s_busy_c%0d", name, c), busy, expBusy);
            if (expWrite) begin
                w = expWords[idx];
                idx++;
                checkOutput($sformatf("%s_d0wr_c%0d", name, c), D0_wr, !w[DEST]);
                checkOutput($sformatf("%s_d1wr_c%0d", name, c), D1_wr, w[DEST]);
                checkOutput($sformatf("%s_d0data_c%0d", name, c), D0_data_in, w);
                checkOutput($sformatf("%s_d1data_c%0d", name, c), D1_data_in, w);
            end else begin
                checkOutput($sformatf("%s_d0wr_c%0d", name, c), D0_wr, 1'b0);
                checkOutput($sformatf("%s_d1wr_c%0d", name, c), D1_wr, 1'b0);
            end
            checkOutput($sformatf("%s_drop_c%0d", name, c), drop_error, 1'b0);
        end
    endtask

    initial begin
        reset_L        = 1'b0;
        forceAvail     = 1'b1;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        D0_full        = 1'b1;
        D1_full        = 1'b1;

        // Reset held with all inputs active
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_rd0", VC0_rd, 1'b0);
        checkOutput("rst_rd1", VC1_rd, 1'b0);
        checkOutput("rst_d0wr", D0_wr, 1'b0);
        checkOutput("rst_d1wr", D1_wr, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_drop", drop_error, 1'b0);
        checkOutput("rst_d0data", D0_data_in, 6'h00);
        checkOutput("rst_d1data", D1_data_in, 6'h00);

        // Release with both VCs empty
        @(negedge clk);
        forceAvail = 1'b0;
        D0_full    = 1'b0;
        D1_full    = 1'b0;
        reset_L    = 1'b1;
        runWindow("idle", 2, 16'h0000, 16'h0000, 16'h0000);

        // Single word routed to D1
        @(negedge clk);
        applyStimulus(0, 6'b010011);
        expWords = '{6'b010011};
        runWindow("single", 4, 16'h0001, 16'h0000, 16'h0000);

        // VC0 strict priority over VC1
        @(negedge clk);
        applyStimulus(0, 6'h01);
        applyStimulus(0, 6'h12);
        applyStimulus(0, 6'h05);
        applyStimulus(1, 6'h1A);
        applyStimulus(1, 6'h23);
        expWords = '{6'h01, 6'h12, 6'h05, 6'h1A, 6'h23};
        runWindow("prio", 8, 16'h0007, 16'h0018, 16'h0000);

        // D0 almost full for cycles 3..6 mid-stream
        @(negedge clk);
        applyStimulus(0, 6'h21);
        applyStimulus(0, 6'h22);
        applyStimulus(0, 6'h03);
        applyStimulus(0, 6'h2C);
        applyStimulus(0, 6'h0F);
        applyStimulus(0, 6'h08);
        expWords = '{6'h21, 6'h22, 6'h03, 6'h2C, 6'h0F, 6'h08};
        runWindow("bp", 13, 16'h03C3, 16'h0000, 16'h003C);

        // Drop: D0-bound word meets D0 full; the following D1-bound word still lands
        @(negedge clk);
        applyStimulus(0, 6'h05);
        applyStimulus(0, 6'h10);
        #1;
        checkOutput("drop_rd0_c1", VC0_rd, 1'b1);
        @(negedge clk);
        D0_full = 1'b1;
        #1;
        checkOutput("drop_rd0_c2", VC0_rd, 1'b1);
        checkOutput("drop_err_c2", drop_error, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("drop_d0wr_c3", D0_wr, 1'b0);
        checkOutput("drop_d1wr_c3", D1_wr, 1'b0);
        checkOutput("drop_err_c3", drop_error, 1'b1);
        checkOutput("drop_busy_c3", busy, 1'b1);
        checkOutput("drop_rd0_c3", VC0_rd, 1'b0);
        @(negedge clk);
        D0_full = 1'b0;
        #1;
        checkOutput("drop_d0wr_c4", D0_wr, 1'b0);
        checkOutput("drop_d1wr_c4", D1_wr, 1'b1);
        checkOutput("drop_d1data_c4", D1_data_in, 6'h10);
        checkOutput("drop_err_c4", drop_error, 1'b1);
`ifdef DEMUX_STATS_EN
        checkOutput("stat_drop", drop_count, 8'd1);
        checkOutput("stat_d1", d1_count, 8'd4);
        checkOutput("stat_d0", d0_count, 8'd9);
`endif
        @(negedge clk);
        #1;
        checkOutput("drop_err_c5", drop_error, 1'b1);
        checkOutput("drop_busy_c5", busy, 1'b0);
        checkOutput("drop_d1wr_c5", D1_wr, 1'b0);

        // Reset asserted the cycle after a pop discards the word
        @(negedge clk);
        applyStimulus(0, 6'h17);
        #1;
        checkOutput("mrst_rd0_c1", VC0_rd, 1'b1);
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        checkOutput("mrst_busy_c2", busy, 1'b0);
        checkOutput("mrst_drop_c2", drop_error, 1'b0);
        checkOutput("mrst_rd0_c2", VC0_rd, 1'b0);
        checkOutput("mrst_d1wr_c2", D1_wr, 1'b0);
        checkOutput("mrst_d1data_c2", D1_data_in, 6'h00);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        checkOutput("mrst_d1wr_c3", D1_wr, 1'b0);
        checkOutput("mrst_busy_c3", busy, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("mrst_d0wr_c4", D0_wr, 1'b0);
        checkOutput("mrst_d1wr_c4", D1_wr, 1'b0);
        checkOutput("mrst_busy_c4", busy, 1'b0);
`ifdef DEMUX_STATS_EN
        checkOutput("mrst_stat_d1", d1_count, 8'd0);
        checkOutput("mrst_stat_drop", drop_count, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
